// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Run controller for an N-bit ALU datapath. Sweeps every
//                operand A/B address pair, captures each result and carry,
//                and keeps an XOR checksum and a result count. Supports a
//                single-step mode for walking the sweep by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
   parameter int N      = 32,
   parameter int ADDR_W = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic                step_mode_i,
   input  logic                step_i,
   input  logic [3:0]          operacion_i,
   input  logic                c_i,
   input  logic                invert_i,
   input  logic [N-1:0]        alu_resultado_i,
   input  logic                alu_c_i,
   output logic [ADDR_W-1:0]   addra_o,
   output logic [ADDR_W-1:0]   addrb_o,
   output logic [3:0]          alu_operacion_o,
   output logic                alu_c_o,
   output logic                alu_invert_o,
   output logic [N-1:0]        resultado_o,
   output logic                carry_o,
   output logic                valid_o,
   output logic [N-1:0]        checksum_o,
   output logic [2*ADDR_W:0]   count_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam int CNT_W = 2*ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_PAUSE   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addra_q, addra_d;
   logic [ADDR_W-1:0]   addrb_q, addrb_d;
   logic [3:0]          op_q, op_d;
   logic                cin_q, cin_d;
   logic                inv_q, inv_d;
   logic                step_mode_q, step_mode_d;
   logic [N-1:0]        res_q, res_d;
   logic                carry_q, carry_d;
   logic                valid_q, valid_d;
   logic [N-1:0]        checksum_q, checksum_d;
   logic [CNT_W-1:0]    count_q, count_d;

   // Last pair of the sweep: both addresses at their maximum value.
   logic                last_pair;
   assign last_pair = (&addra_q) & (&addrb_q);

   // State register and all datapath registers; reset clears every output.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         addra_q     <= '0;
         addrb_q     <= '0;
         op_q        <= '0;
         cin_q       <= 1'b0;
         inv_q       <= 1'b0;
         step_mode_q <= 1'b0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         valid_q     <= 1'b0;
         checksum_q  <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         addra_q     <= addra_d;
         addrb_q     <= addrb_d;
         op_q        <= op_d;
         cin_q       <= cin_d;
         inv_q       <= inv_d;
         step_mode_q <= step_mode_d;
         res_q       <= res_d;
         carry_q     <= carry_d;
         valid_q     <= valid_d;
         checksum_q  <= checksum_d;
         count_q     <= count_d;
      end
   end

   // Next-state and datapath update; everything holds unless a state acts.
   always_comb begin
      state_d     = state_q;
      addra_d     = addra_q;
      addrb_d     = addrb_q;
      op_d        = op_q;
      cin_d       = cin_q;
      inv_d       = inv_q;
      step_mode_d = step_mode_q;
      res_d       = res_q;
      carry_d     = carry_q;
      valid_d     = 1'b0;
      checksum_d  = checksum_q;
      count_d     = count_q;

      case (state_q)
         S_IDLE: begin
            // abort_i wins over start_i, so both together leave us idle.
            if (start_i && !abort_i) begin
               op_d        = operacion_i;
               cin_d       = c_i;
               inv_d       = invert_i;
               step_mode_d = step_mode_i;
               addra_d     = '0;
               addrb_d     = '0;
               checksum_d  = '0;
               count_d     = '0;
               state_d     = S_ISSUE;
            end
         end

         S_ISSUE: begin
            // One settle cycle for the operand memories and the ALU.
            state_d = abort_i ? S_IDLE : S_CAPTURE;
         end

         S_CAPTURE: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else begin
               res_d      = alu_resultado_i;
               carry_d    = alu_c_i;
               valid_d    = 1'b1;
               checksum_d = checksum_q ^ alu_resultado_i;
               count_d    = count_q + CNT_W'(1);
               if (last_pair) begin
                  state_d = S_DONE;
               end else begin
                  addrb_d = addrb_q + ADDR_W'(1);
                  if (&addrb_q) begin
                     addra_d = addra_q + ADDR_W'(1);
                  end
                  state_d = step_mode_q ? S_PAUSE : S_ISSUE;
               end
            end
         end

         S_PAUSE: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (step_i) begin
               state_d = S_ISSUE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign addra_o         = addra_q;
   assign addrb_o         = addrb_q;
   assign alu_operacion_o = op_q;
   assign alu_c_o         = cin_q;
   assign alu_invert_o    = inv_q;
   assign resultado_o     = res_q;
   assign carry_o         = carry_q;
   assign valid_o         = valid_q;
   assign checksum_o      = checksum_q;
   assign count_o         = count_q;
   assign busy_o          = (state_q != S_IDLE);
   assign done_o          = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Scoreboard bench for alu_sequencer. The ALU model returns
//                addra*8 + addrb + 1 with carry = addra[0] & addrb[0].
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

   localparam int N      = 32;
   localparam int ADDR_W = 3;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic          step_mode_i = 1'b0;
   logic          step_i = 1'b0;
   logic [3:0]    operacion_i = 4'd0;
   logic          c_i = 1'b0;
   logic          invert_i = 1'b0;
   logic [N-1:0]  alu_resultado_i;
   logic          alu_c_i;
   logic [ADDR_W-1:0] addra_o, addrb_o;
   logic [3:0]    alu_operacion_o;
   logic          alu_c_o, alu_invert_o;
   logic [N-1:0]  resultado_o;
   logic          carry_o, valid_o;
   logic [N-1:0]  checksum_o;
   logic [2*ADDR_W:0] count_o;
   logic          busy_o, done_o;

   alu_sequencer #(.N(N), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .step_mode_i(step_mode_i), .step_i(step_i), .operacion_i(operacion_i),
      .c_i(c_i), .invert_i(invert_i), .alu_resultado_i(alu_resultado_i),
      .alu_c_i(alu_c_i), .addra_o(addra_o), .addrb_o(addrb_o),
      .alu_operacion_o(alu_operacion_o), .alu_c_o(alu_c_o),
      .alu_invert_o(alu_invert_o), .resultado_o(resultado_o),
      .carry_o(carry_o), .valid_o(valid_o), .checksum_o(checksum_o),
      .count_o(count_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   // Combinational ALU model driven from the address outputs.
   assign alu_resultado_i = N'({addra_o, addrb_o}) + 32'd1;
   assign alu_c_i         = addra_o[0] & addrb_o[0];

   typedef struct {
      logic [N-1:0] res;
      logic         c;
      int           cnt;
      logic [3:0]   op;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   int   n_valid = 0;
   int   n_done = 0;
   int   done_edge = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Queue expected captures for pair indices [first, first+n).
   task automatic push_pairs(input int first, input int n, input logic [3:0] op);
      exp_t e;
      for (int i = first; i < first + n; i++) begin
         e.res = N'(i + 1);
         e.c   = ((i / 8) % 2 == 1) && ((i % 8) % 2 == 1);
         e.cnt = i + 1;
         e.op  = op;
         sb.push_back(e);
      end
   endtask

   always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

   // Monitor: compare every valid_o against the head of the scoreboard.
   always @(posedge clk_i) begin
      #1;
      if (done_o) begin
         n_done++;
         done_edge = edge_cnt;
      end
      if (valid_o) begin
         exp_t e;
         n_valid++;
         if (sb.size() == 0) begin
            chk("unexpected_valid", 64'(resultado_o), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("resultado", 64'(resultado_o), 64'(e.res));
            chk("carry", 64'(carry_o), 64'(e.c));
            chk("count_at_valid", 64'(count_o), 64'(e.cnt));
            chk("alu_operacion", 64'(alu_operacion_o), 64'(e.op));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic start_sweep(input logic [3:0] op, input logic cin, input logic inv,
                              input logic smode, output int k);
      @(negedge clk_i);
      operacion_i = op; c_i = cin; invert_i = inv; step_mode_i = smode; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      k = edge_cnt;
   endtask

   task automatic pulse_step();
      step_i = 1'b1;
      @(negedge clk_i);
      step_i = 1'b0;
      cycles(3);
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while (busy_o && t < budget) begin
         @(negedge clk_i);
         t++;
      end
      if (busy_o) chk("wait_idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic wait_count(input int target, input int budget);
      int t = 0;
      while (int'(count_o) != target && t < budget) begin
         @(negedge clk_i);
         t++;
      end
      if (int'(count_o) != target) chk("wait_count_timeout", 64'(count_o), 64'(target));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_addra"}, 64'(addra_o), 64'd0);
      chk({tag, "_addrb"}, 64'(addrb_o), 64'd0);
      chk({tag, "_ctrl"}, 64'({alu_operacion_o, alu_c_o, alu_invert_o}), 64'd0);
      chk({tag, "_res"}, 64'({carry_o, resultado_o}), 64'd0);
      chk({tag, "_checksum"}, 64'(checksum_o), 64'd0);
      chk({tag, "_count"}, 64'(count_o), 64'd0);
      chk({tag, "_flags"}, 64'({valid_o, busy_o, done_o}), 64'd0);
   endtask

   initial begin
      int k;
      int d0;
      cycles(3);
      rst_i = 1'b0;
      check_zero("reset");

      // Full free-running sweep.
      push_pairs(0, 64, 4'b0010);
      n_valid = 0;
      start_sweep(4'b0010, 1'b1, 1'b0, 1'b0, k);
      chk("busy_after_start", 64'(busy_o), 64'd1);
      wait_idle(300);
      cycles(2);
      chk("sweep_valids", 64'(n_valid), 64'd64);
      chk("sweep_count", 64'(count_o), 64'd64);
      chk("sweep_checksum", 64'(checksum_o), 64'h40);
      chk("sweep_done_edge", 64'(done_edge), 64'(k + 128));
      chk("sweep_done_count", 64'(n_done), 64'd1);
      chk("sweep_sb_empty", 64'(sb.size()), 64'd0);
      chk("latched_cin_inv", 64'({alu_c_o, alu_invert_o}), 64'b10);
      chk("idle_hold_res", 64'(resultado_o), 64'd64);

      // Step mode: one capture, then hold in PAUSE.
      push_pairs(0, 10, 4'b0101);
      start_sweep(4'b0101, 1'b0, 1'b1, 1'b1, k);
      cycles(22);
      chk("step_hold_count", 64'(count_o), 64'd1);
      chk("step_hold_busy", 64'(busy_o), 64'd1);
      chk("step_latched_inv", 64'(alu_invert_o), 64'd1);
      // start_i while busy must be ignored.
      start_i = 1'b1;
      cycles(1);
      start_i = 1'b0;
      cycles(2);
      chk("start_busy_count", 64'(count_o), 64'd1);
      chk("start_busy_addrb", 64'(addrb_o), 64'd1);
      repeat (3) pulse_step();
      chk("step3_count", 64'(count_o), 64'd4);
      chk("step3_addrb", 64'(addrb_o), 64'd4);
      chk("step3_addra", 64'(addra_o), 64'd0);
      chk("step3_checksum", 64'(checksum_o), 64'd4);
      repeat (6) pulse_step();
      chk("step10_count", 64'(count_o), 64'd10);
      // Abort while paused.
      d0 = n_done;
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      chk("abort_pause_busy", 64'(busy_o), 64'd0);
      chk("abort_pause_count", 64'(count_o), 64'd10);
      chk("abort_pause_checksum", 64'(checksum_o), 64'hB);
      cycles(4);
      chk("abort_pause_nodone", 64'(n_done), 64'(d0));

      // Abort in ISSUE during a free run.
      push_pairs(0, 10, 4'b1100);
      start_sweep(4'b1100, 1'b0, 1'b0, 1'b0, k);
      wait_count(10, 60);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      chk("abort_issue_busy", 64'(busy_o), 64'd0);
      cycles(4);
      chk("abort_issue_count", 64'(count_o), 64'd10);
      chk("abort_issue_nodone", 64'(n_done), 64'(d0));
      chk("abort_issue_sb", 64'(sb.size()), 64'd0);

      // start_i and abort_i together in IDLE.
      start_i = 1'b1; abort_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; abort_i = 1'b0;
      cycles(2);
      chk("start_abort_busy", 64'(busy_o), 64'd0);
      chk("start_abort_count", 64'(count_o), 64'd10);

      // Reset in the middle of a sweep.
      push_pairs(0, 64, 4'b0111);
      start_sweep(4'b0111, 1'b1, 1'b1, 1'b0, k);
      cycles(15);
      rst_i = 1'b1;
      sb.delete();
      cycles(2);
      rst_i = 1'b0;
      check_zero("midreset");
      d0 = n_done;
      cycles(10);
      chk("midreset_nodone", 64'(n_done), 64'(d0));
      chk("midreset_idle", 64'(busy_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
